// File: rtl/rob_retire.sv
// Dual-issue in-order reorder buffer: allocates up to 2 entries per cycle, completes out of order
// by tag, and retires up to 2 oldest completed entries onto registered register-file write ports.
module rob_retire #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 16,
    parameter int unsigned RW    = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          alloc_valid_0,
    input  logic [RW-1:0] alloc_rd_0,
    input  logic          alloc_valid_1,
    input  logic [RW-1:0] alloc_rd_1,
    output logic          alloc_ready,
    output logic [AW-1:0] alloc_tag_0,
    output logic [AW-1:0] alloc_tag_1,
    input  logic          cmpl_valid_0,
    input  logic [AW-1:0] cmpl_tag_0,
    input  logic [DW-1:0] cmpl_data_0,
    input  logic          cmpl_valid_1,
    input  logic [AW-1:0] cmpl_tag_1,
    input  logic [DW-1:0] cmpl_data_1,
    output logic [RW-1:0] wb_addr_0,
    output logic [DW-1:0] wb_data_0,
    output logic [RW-1:0] wb_addr_1,
    output logic [DW-1:0] wb_data_1,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [AW-1:0]    head_q, head_d, tail_q, tail_d, head_nx;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
    logic [RW-1:0]    rd_q   [DEPTH];
    logic [RW-1:0]    rd_d   [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [RW-1:0]    wb_addr_0_q, wb_addr_0_d, wb_addr_1_q, wb_addr_1_d;
    logic [DW-1:0]    wb_data_0_q, wb_data_0_d, wb_data_1_q, wb_data_1_d;
    logic             acc0, acc1, ret0, ret1, same_dst;

    assign alloc_ready = (count_q <= (AW+1)'(DEPTH - 2));
    assign alloc_tag_0 = tail_q;
    assign alloc_tag_1 = tail_q + AW'(1);
    assign head_nx     = head_q + AW'(1);

    assign acc0     = alloc_valid_0 & alloc_ready;
    assign acc1     = acc0 & alloc_valid_1;
    assign ret0     = valid_q[head_q] & done_q[head_q];
    assign ret1     = ret0 & valid_q[head_nx] & done_q[head_nx];
    // Only the younger of two same-register retirements reaches the register file.
    assign same_dst = ret1 && (rd_q[head_q] == rd_q[head_nx]) && (rd_q[head_q] != '0);

    always_comb begin
        valid_d     = valid_q;
        done_d      = done_q;
        rd_d        = rd_q;
        data_d      = data_q;
        head_d      = head_q + AW'(ret0) + AW'(ret1);
        tail_d      = tail_q + AW'(acc0) + AW'(acc1);
        count_d     = count_q + (AW+1)'(acc0) + (AW+1)'(acc1) - (AW+1)'(ret0) - (AW+1)'(ret1);
        wb_addr_0_d = '0;
        wb_addr_1_d = '0;
        wb_data_0_d = wb_data_0_q;
        wb_data_1_d = wb_data_1_q;

        // Port 1 is applied last so it wins on a shared tag.
        if (cmpl_valid_0 && valid_q[cmpl_tag_0]) begin
            done_d[cmpl_tag_0] = 1'b1;
            data_d[cmpl_tag_0] = cmpl_data_0;
        end
        if (cmpl_valid_1 && valid_q[cmpl_tag_1]) begin
            done_d[cmpl_tag_1] = 1'b1;
            data_d[cmpl_tag_1] = cmpl_data_1;
        end

        if (ret0) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            if (!same_dst && rd_q[head_q] != '0) begin
                wb_addr_0_d = rd_q[head_q];
                wb_data_0_d = data_q[head_q];
            end
        end
        if (ret1) begin
            valid_d[head_nx] = 1'b0;
            done_d[head_nx]  = 1'b0;
            if (rd_q[head_nx] != '0) begin
                wb_addr_1_d = rd_q[head_nx];
                wb_data_1_d = data_q[head_nx];
            end
        end

        // Free space guarantees the tail slots are never the ones retiring.
        if (acc0) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            rd_d[tail_q]    = alloc_rd_0;
        end
        if (acc1) begin
            valid_d[alloc_tag_1] = 1'b1;
            done_d[alloc_tag_1]  = 1'b0;
            rd_d[alloc_tag_1]    = alloc_rd_1;
        end

        if (flush) begin
            valid_d     = '0;
            done_d      = '0;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            wb_addr_0_d = '0;
            wb_addr_1_d = '0;
            wb_data_0_d = wb_data_0_q;
            wb_data_1_d = wb_data_1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            done_q      <= '0;
            rd_q        <= '{default: '0};
            data_q      <= '{default: '0};
            wb_addr_0_q <= '0;
            wb_addr_1_q <= '0;
            wb_data_0_q <= '0;
            wb_data_1_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            wb_addr_0_q <= wb_addr_0_d;
            wb_addr_1_q <= wb_addr_1_d;
            wb_data_0_q <= wb_data_0_d;
            wb_data_1_q <= wb_data_1_d;
        end
    end

    assign wb_addr_0 = wb_addr_0_q;
    assign wb_addr_1 = wb_addr_1_q;
    assign wb_data_0 = wb_data_0_q;
    assign wb_data_1 = wb_data_1_q;
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: a vector table for single-cycle behaviour plus hand-written
// sequences for fill/backpressure, streaming with wrap, flush and asynchronous reset.
module tb_rob_retire;

    logic        clk = 1'b0;
    logic        reset_n, flush;
    logic        alloc_valid_0, alloc_valid_1, alloc_ready;
    logic [2:0]  alloc_rd_0, alloc_rd_1, alloc_tag_0, alloc_tag_1;
    logic        cmpl_valid_0, cmpl_valid_1;
    logic [2:0]  cmpl_tag_0, cmpl_tag_1;
    logic [15:0] cmpl_data_0, cmpl_data_1;
    logic [2:0]  wb_addr_0, wb_addr_1;
    logic [15:0] wb_data_0, wb_data_1;
    logic [3:0]  count;
    logic        empty, full;

    rob_retire #(.DEPTH(8), .AW(3), .DW(16), .RW(3)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .alloc_valid_0(alloc_valid_0), .alloc_rd_0(alloc_rd_0),
        .alloc_valid_1(alloc_valid_1), .alloc_rd_1(alloc_rd_1),
        .alloc_ready(alloc_ready), .alloc_tag_0(alloc_tag_0), .alloc_tag_1(alloc_tag_1),
        .cmpl_valid_0(cmpl_valid_0), .cmpl_tag_0(cmpl_tag_0), .cmpl_data_0(cmpl_data_0),
        .cmpl_valid_1(cmpl_valid_1), .cmpl_tag_1(cmpl_tag_1), .cmpl_data_1(cmpl_data_1),
        .wb_addr_0(wb_addr_0), .wb_data_0(wb_data_0),
        .wb_addr_1(wb_addr_1), .wb_data_1(wb_data_1),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a0;  logic [2:0] rd0; logic a1; logic [2:0] rd1;
        logic        c0v; logic [2:0] c0t; logic [15:0] c0d;
        logic        c1v; logic [2:0] c1t; logic [15:0] c1d;
        logic [2:0]  wa0; logic [15:0] wd0; logic [2:0] wa1; logic [15:0] wd1;
        logic [3:0]  cnt; logic rdy;
    } vec_t;

    vec_t tbl[18];
    int   errors = 0;
    int   checks = 0;
    int   exp_i  = 0;
    bit   mon_en = 1'b0;
    logic [2:0] tags[20];

    function automatic vec_t mk(int a0, int rd0, int a1, int rd1, int c0v, int c0t, int c0d,
                                int c1v, int c1t, int c1d, int wa0, int wd0, int wa1, int wd1,
                                int cnt, int rdy);
        vec_t v;
        v.a0 = a0[0];   v.rd0 = rd0[2:0]; v.a1 = a1[0];   v.rd1 = rd1[2:0];
        v.c0v = c0v[0]; v.c0t = c0t[2:0]; v.c0d = c0d[15:0];
        v.c1v = c1v[0]; v.c1t = c1t[2:0]; v.c1d = c1d[15:0];
        v.wa0 = wa0[2:0]; v.wd0 = wd0[15:0]; v.wa1 = wa1[2:0]; v.wd1 = wd1[15:0];
        v.cnt = cnt[3:0]; v.rdy = rdy[0];
        return v;
    endfunction

    function automatic logic [2:0] rd_of(int i);
        int r;
        r = (i % 7) + 1;
        return r[2:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        flush = 0; alloc_valid_0 = 0; alloc_valid_1 = 0; alloc_rd_0 = 0; alloc_rd_1 = 0;
        cmpl_valid_0 = 0; cmpl_valid_1 = 0; cmpl_tag_0 = 0; cmpl_tag_1 = 0;
        cmpl_data_0 = 0; cmpl_data_1 = 0;
    endtask

    // Advance one edge; in stream mode every nonzero writeback is matched in program order.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (wb_addr_0 != 0) begin
                chk("stream wb_addr_0", 32'(wb_addr_0), 32'(rd_of(exp_i)));
                chk("stream wb_data_0", 32'(wb_data_0), 32'(exp_i));
                exp_i++;
            end
            if (wb_addr_1 != 0) begin
                chk("stream wb_addr_1", 32'(wb_addr_1), 32'(rd_of(exp_i)));
                chk("stream wb_data_1", 32'(wb_data_1), 32'(exp_i));
                exp_i++;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 0;
        #3;
        reset_n = 1;
    endtask

    task automatic alloc(input logic v1, input logic [2:0] r0, input logic [2:0] r1);
        alloc_valid_0 = 1; alloc_rd_0 = r0; alloc_valid_1 = v1; alloc_rd_1 = r1;
        tick();
        clr();
    endtask

    task automatic cmpl(input logic [2:0] t0, input logic [15:0] d0,
                        input logic v1, input logic [2:0] t1, input logic [15:0] d1);
        cmpl_valid_0 = 1; cmpl_tag_0 = t0; cmpl_data_0 = d0;
        cmpl_valid_1 = v1; cmpl_tag_1 = t1; cmpl_data_1 = d1;
        tick();
        clr();
    endtask

    initial begin
        clr();
        reset_n = 0;
        #12;
        chk("reset count", 32'(count), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset wb_addr_0", 32'(wb_addr_0), 32'd0);
        chk("reset wb_data_1", 32'(wb_data_1), 32'd0);
        reset_n = 1;
        @(posedge clk);
        #1;

        // a0 rd0 a1 rd1 | c0v c0t c0d | c1v c1t c1d | wa0 wd0 wa1 wd1 | cnt rdy
        tbl[0]  = mk(1, 1, 1, 2, 0, 0, 0,       0, 0, 0,       0, 0,       0, 0,       2, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0,       1, 1, 'hBEEF, 0, 0,       0, 0,       2, 1);
        tbl[2]  = mk(0, 0, 0, 0, 1, 0, 'h1234, 0, 0, 0,       0, 0,       0, 0,       2, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       1, 'h1234, 2, 'hBEEF, 0, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,       0, 0,       0, 1);
        tbl[5]  = mk(1, 3, 1, 3, 0, 0, 0,       0, 0, 0,       0, 0,       0, 0,       2, 1);
        tbl[6]  = mk(0, 0, 0, 0, 1, 2, 'h0011, 1, 3, 'h0022, 0, 0,       0, 0,       2, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,       3, 'h0022, 0, 1);
        tbl[8]  = mk(1, 0, 1, 5, 0, 0, 0,       0, 0, 0,       0, 0,       0, 0,       2, 1);
        tbl[9]  = mk(0, 0, 0, 0, 1, 5, 'hAAAA, 1, 5, 'h5555, 0, 0,       0, 0,       2, 1);
        tbl[10] = mk(0, 0, 0, 0, 1, 4, 'h0777, 0, 0, 0,       0, 0,       0, 0,       2, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,       5, 'h5555, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 1, 6, 'h9999, 0, 0, 0,       0, 0,       0, 0,       0, 1);
        tbl[13] = mk(1, 4, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,       0, 0,       1, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       0, 0,       0, 0,       1, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,       1, 6, 'h0666, 0, 0,       0, 0,       1, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,       0, 0, 0,       4, 'h0666, 0, 0,       0, 1);
        tbl[17] = mk(0, 0, 1, 7, 0, 0, 0,       0, 0, 0,       0, 0,       0, 0,       0, 1);

        for (int i = 0; i < 18; i++) begin
            alloc_valid_0 = tbl[i].a0;  alloc_rd_0 = tbl[i].rd0;
            alloc_valid_1 = tbl[i].a1;  alloc_rd_1 = tbl[i].rd1;
            cmpl_valid_0 = tbl[i].c0v;  cmpl_tag_0 = tbl[i].c0t;  cmpl_data_0 = tbl[i].c0d;
            cmpl_valid_1 = tbl[i].c1v;  cmpl_tag_1 = tbl[i].c1t;  cmpl_data_1 = tbl[i].c1d;
            tick();
            clr();
            chk($sformatf("vec%0d wb_addr_0", i), 32'(wb_addr_0), 32'(tbl[i].wa0));
            chk($sformatf("vec%0d wb_addr_1", i), 32'(wb_addr_1), 32'(tbl[i].wa1));
            if (tbl[i].wa0 != 0) chk($sformatf("vec%0d wb_data_0", i), 32'(wb_data_0),
                                     32'(tbl[i].wd0));
            if (tbl[i].wa1 != 0) chk($sformatf("vec%0d wb_data_1", i), 32'(wb_data_1),
                                     32'(tbl[i].wd1));
            chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d alloc_ready", i), 32'(alloc_ready), 32'(tbl[i].rdy));
        end

        // Fill to capacity, then show backpressure lifts only after retirement.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            alloc(1'b1, rd_of(2 * p), rd_of(2 * p + 1));
            chk($sformatf("fill count p%0d", p), 32'(count), 32'(2 * p + 2));
        end
        chk("fill full", 32'(full), 32'd1);
        chk("fill alloc_ready", 32'(alloc_ready), 32'd0);
        alloc(1'b1, 3'd7, 3'd7);
        chk("fill 5th pair ignored", 32'(count), 32'd8);
        cmpl(3'd0, 16'h0100, 1'b1, 3'd1, 16'h0101);
        chk("fill ready before retire", 32'(alloc_ready), 32'd0);
        tick();
        chk("fill count after retire", 32'(count), 32'd6);
        chk("fill ready after retire", 32'(alloc_ready), 32'd1);
        chk("fill wb_addr_0", 32'(wb_addr_0), 32'(rd_of(0)));
        chk("fill wb_addr_1", 32'(wb_addr_1), 32'(rd_of(1)));
        chk("fill wb_data_1", 32'(wb_data_1), 32'h0101);

        // 20-instruction stream, reverse completion within groups of 4, tags wrap.
        do_reset();
        exp_i  = 0;
        mon_en = 1'b1;
        for (int g = 0; g < 5; g++) begin
            for (int p = 0; p < 2; p++) begin
                tags[4 * g + 2 * p]     = alloc_tag_0;
                tags[4 * g + 2 * p + 1] = alloc_tag_1;
                alloc(1'b1, rd_of(4 * g + 2 * p), rd_of(4 * g + 2 * p + 1));
            end
            cmpl(tags[4 * g + 3], 16'(4 * g + 3), 1'b1, tags[4 * g + 2], 16'(4 * g + 2));
            cmpl(tags[4 * g + 1], 16'(4 * g + 1), 1'b1, tags[4 * g], 16'(4 * g));
        end
        for (int w = 0; w < 20 && exp_i < 20; w++) tick();
        mon_en = 1'b0;
        chk("stream writebacks", 32'(exp_i), 32'd20);
        chk("stream tag wrap", 32'(tags[8]), 32'd0);
        chk("stream drained", 32'(count), 32'd0);

        // Flush with done entries and a retirement due at the same edge.
        do_reset();
        alloc(1'b1, 3'd1, 3'd2);
        alloc(1'b1, 3'd3, 3'd4);
        alloc(1'b0, 3'd5, 3'd0);
        cmpl(3'd1, 16'h0AA1, 1'b1, 3'd2, 16'h0AA2);
        cmpl(3'd3, 16'h0AA3, 1'b1, 3'd0, 16'h0AA0);
        chk("flush pre count", 32'(count), 32'd5);
        chk("flush pre wb_addr_0", 32'(wb_addr_0), 32'd0);
        flush = 1;
        tick();
        clr();
        chk("flush count", 32'(count), 32'd0);
        chk("flush empty", 32'(empty), 32'd1);
        chk("flush wb_addr_0", 32'(wb_addr_0), 32'd0);
        chk("flush wb_addr_1", 32'(wb_addr_1), 32'd0);
        tick();
        chk("flush after wb_addr_0", 32'(wb_addr_0), 32'd0);
        chk("flush after wb_addr_1", 32'(wb_addr_1), 32'd0);
        chk("flush next tag", 32'(alloc_tag_0), 32'd0);
        alloc(1'b0, 3'd6, 3'd0);
        chk("flush realloc count", 32'(count), 32'd1);

        // Asynchronous reset while a retirement is pending.
        do_reset();
        alloc(1'b1, 3'd1, 3'd2);
        alloc(1'b1, 3'd3, 3'd4);
        cmpl(3'd0, 16'h00A0, 1'b1, 3'd1, 16'h00A1);
        cmpl(3'd2, 16'h00B2, 1'b1, 3'd3, 16'h00B3);
        chk("areset pre wb_addr_0", 32'(wb_addr_0), 32'd1);
        #1;
        reset_n = 0;
        #1;
        chk("areset wb_addr_0", 32'(wb_addr_0), 32'd0);
        chk("areset wb_addr_1", 32'(wb_addr_1), 32'd0);
        chk("areset wb_data_0", 32'(wb_data_0), 32'd0);
        chk("areset count", 32'(count), 32'd0);
        chk("areset empty", 32'(empty), 32'd1);
        #2;
        reset_n = 1;
        chk("areset tag_0", 32'(alloc_tag_0), 32'd0);
        chk("areset tag_1", 32'(alloc_tag_1), 32'd1);
        alloc(1'b1, 3'd5, 3'd6);
        chk("areset realloc count", 32'(count), 32'd2);
        chk("areset no stale wb", 32'(wb_addr_0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
